// File: rtl/multi_bullet_control.sv
// multi_bullet_control: manages a pool of player bullets.
// Fire is edge-triggered and gated by a cooldown timer. All live bullets
// step upward together at a fixed rate. Each slot is retired when it is hit
// or when it leaves the top of the screen. Enemy health drops by the number
// of valid hits in a cycle and saturates at zero.
module multi_bullet_control #(
    parameter int NUM_BULLETS  = 4,
    parameter int RATE_DIV     = 500000,
    parameter int COOLDOWN     = 2000000,
    parameter int PLAYER_WIDTH = 3,
    parameter int HP_W         = 3,
    parameter int HEALTH_INIT  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic                     load_level,
    input  logic                     fire,
    input  logic [7:0]               playerX,
    input  logic [6:0]               playerY,
    input  logic [NUM_BULLETS-1:0]   bullet_hit,
    output logic [NUM_BULLETS-1:0]   active,
    output logic [8*NUM_BULLETS-1:0] bulletX,
    output logic [7*NUM_BULLETS-1:0] bulletY,
    output logic                     move,
    output logic [HP_W-1:0]          health,
    output logic                     enemy_dead
);

    localparam int RATE_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int CNT_W  = $clog2(NUM_BULLETS + 1);
    localparam int SUB_W  = (HP_W > CNT_W) ? HP_W : CNT_W;

    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN);
    localparam logic [HP_W-1:0]   HP_INIT   = HP_W'(HEALTH_INIT);
    localparam logic [7:0]        X_OFS     = 8'(PLAYER_WIDTH / 2);

    // Health never wraps: subtracting more hits than remain leaves zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0]  a,
                                                input logic [CNT_W-1:0] b);
        logic [SUB_W-1:0] aw;
        logic [SUB_W-1:0] bw;
        aw = SUB_W'(a);
        bw = SUB_W'(b);
        if (bw >= aw) begin
            return '0;
        end
        return HP_W'(aw - bw);
    endfunction

    logic [NUM_BULLETS-1:0]        active_q, active_d;
    logic [NUM_BULLETS-1:0][7:0]   x_q, x_d;
    logic [NUM_BULLETS-1:0][6:0]   y_q, y_d;
    logic                          move_q, move_d;
    logic [RATE_W-1:0]             rate_q, rate_d;
    logic [CD_W-1:0]               cd_q, cd_d;
    logic                          fire_q;
    logic [HP_W-1:0]               health_q, health_d;

    logic                          fire_rise;
    logic                          any_free;
    logic                          spawn;
    logic                          step;
    logic [NUM_BULLETS-1:0]        hit_vld;
    logic [NUM_BULLETS-1:0]        spawn_oh;
    logic [CNT_W-1:0]              hit_cnt;

    // Spawn, step and hit qualification all use the state at cycle start.
    assign fire_rise = fire & ~fire_q;
    assign any_free  = ~&active_q;
    assign spawn     = play & fire_rise & (cd_q == '0) & any_free & (playerY != 7'd0);
    assign step      = play & (|active_q) & (rate_q == RATE_LAST);
    assign hit_vld   = play ? (active_q & bullet_hit) : '0;

    // Select the lowest-index free slot as a one-hot mask.
    always_comb begin
        logic found;
        found    = 1'b0;
        spawn_oh = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!active_q[i] && !found) begin
                spawn_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Count the valid hits in this cycle.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_cnt = hit_cnt + CNT_W'(hit_vld[i]);
        end
    end

    // Per-slot next state. A hit takes priority over a step. A spawn only
    // targets a slot that was free at cycle start, so it cannot collide with
    // a hit or step on the same slot.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (hit_vld[i]) begin
                active_d[i] = 1'b0;
                x_d[i]      = 8'd0;
                y_d[i]      = 7'd0;
            end else if (step && active_q[i]) begin
                if (y_q[i] == 7'd0) begin
                    active_d[i] = 1'b0;
                    x_d[i]      = 8'd0;
                    y_d[i]      = 7'd0;
                end else begin
                    y_d[i] = y_q[i] - 7'd1;
                end
            end else if (spawn && spawn_oh[i]) begin
                active_d[i] = 1'b1;
                x_d[i]      = playerX + X_OFS;
                y_d[i]      = playerY - 7'd1;
            end
        end
    end

    // Rate divider, cooldown timer, health and the move pulse.
    always_comb begin
        rate_d   = rate_q;
        cd_d     = cd_q;
        health_d = sat_sub(health_q, hit_cnt);
        move_d   = step;
        if (play) begin
            if (!(|active_q) || rate_q == RATE_LAST) begin
                rate_d = '0;
            end else begin
                rate_d = rate_q + RATE_W'(1);
            end
            if (spawn) begin
                cd_d = CD_LOAD;
            end else if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end
        end
    end

    // State registers. A level load re-initialises everything, just like reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            move_q   <= 1'b0;
            rate_q   <= '0;
            cd_q     <= '0;
            fire_q   <= 1'b0;
            health_q <= HP_INIT;
        end else if (load_level) begin
            active_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            move_q   <= 1'b0;
            rate_q   <= '0;
            cd_q     <= '0;
            fire_q   <= 1'b0;
            health_q <= HP_INIT;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
            move_q   <= move_d;
            rate_q   <= rate_d;
            cd_q     <= cd_d;
            fire_q   <= fire;
            health_q <= health_d;
        end
    end

    assign active     = active_q;
    assign bulletX    = x_q;
    assign bulletY    = y_q;
    assign move       = move_q;
    assign health     = health_q;
    assign enemy_dead = (health_q == '0);

endmodule
